// File: rtl/conway_pkg.sv
// Shared constants and scanner state encoding for the LED cube display path.
// Cell index convention: z*64 + y*8 + x.
package conway_pkg;
    localparam int CUBE_DIM   = 8;
    localparam int LAYER_BITS = 64;
    localparam int CELL_BITS  = 512;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_SHIFT = 3'd2,
        ST_LATCH = 3'd3,
        ST_DWELL = 3'd4
    } scan_state_t;

    function automatic logic [CUBE_DIM-1:0] layer_onehot(input logic [2:0] z);
        layer_onehot    = '0;
        layer_onehot[z] = 1'b1;
    endfunction
endpackage

// File: rtl/col_shifter.sv
// 64-bit parallel-in/serial-out column shifter with SerClk divider, MSB first.
// busy drops during the final shift cycle so the caller can change state on the same edge.
module col_shifter
    import conway_pkg::*;
#(
    parameter int SHIFT_HALF = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [LAYER_BITS-1:0] data,
    input  logic                  start,
    output logic                  busy,
    output logic                  sclk,
    output logic                  sdata
);
    logic [LAYER_BITS-1:0] sreg;
    logic [7:0]            phase;
    logic [5:0]            bit_cnt;
    logic                  active;
    logic                  phase_end;

    assign phase_end = (phase == 8'(SHIFT_HALF - 1));
    assign busy      = active && !(phase_end && sclk && (bit_cnt == 6'd63));
    assign sdata     = sreg[LAYER_BITS-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg    <= '0;
            phase   <= '0;
            bit_cnt <= '0;
            active  <= 1'b0;
            sclk    <= 1'b0;
        end else begin
            if (load) begin
                sreg <= data;
            end else if (active && phase_end && sclk) begin
                // Data advances on the falling SerClk edge so it is stable across the rise.
                sreg <= {sreg[LAYER_BITS-2:0], 1'b0};
            end

            if (start) begin
                active  <= 1'b1;
                phase   <= '0;
                bit_cnt <= '0;
                sclk    <= 1'b0;
            end else if (active) begin
                if (phase_end) begin
                    phase <= '0;
                    if (!sclk) begin
                        sclk <= 1'b1;
                    end else begin
                        sclk    <= 1'b0;
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'd63) begin
                            active <= 1'b0;
                        end
                    end
                end else begin
                    phase <= phase + 8'd1;
                end
            end
        end
    end
endmodule

// File: rtl/cube_scan.sv
// Multiplexed 8x8x8 LED cube scanner: per layer load, shift 64 columns, latch, dwell.
// Frame snapshot taken at layer 0 so mid-frame Cells updates never tear the image.
module cube_scan
    import conway_pkg::*;
#(
    parameter int SHIFT_HALF   = 2,
    parameter int DWELL_CYCLES = 1000
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [CELL_BITS-1:0] Cells,
    input  logic                 Enable,
    input  logic                 Blank,
    output logic                 SerClk,
    output logic                 SerData,
    output logic                 SerLatch,
    output logic [CUBE_DIM-1:0]  LayerSel,
    output logic                 FrameStart
);
    scan_state_t           state, next_state;
    logic [2:0]            z, z_next;
    logic [15:0]           dwell_cnt;
    logic                  dwell_end;
    logic [CELL_BITS-1:0]  snapshot;
    logic [CELL_BITS-1:0]  layer_src;
    logic [LAYER_BITS-1:0] layer_data;
    logic                  load_layer;
    logic                  sh_busy;

    assign dwell_end  = (dwell_cnt == 16'(DWELL_CYCLES - 1));
    assign load_layer = (state == ST_LOAD);

    always_comb begin
        layer_src  = (z == 3'd0) ? Cells : snapshot;
        layer_data = layer_src[{z, 6'd0} +: LAYER_BITS];
    end

    always_comb begin
        next_state = state;
        z_next     = z;
        case (state)
            ST_IDLE:  if (Enable) next_state = ST_LOAD;
            ST_LOAD:  next_state = ST_SHIFT;
            ST_SHIFT: if (!sh_busy) next_state = ST_LATCH;
            ST_LATCH: next_state = ST_DWELL;
            ST_DWELL: begin
                if (dwell_end) begin
                    z_next     = z + 3'd1;
                    next_state = Enable ? ST_LOAD : ST_IDLE;
                end
            end
            default:  next_state = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state      <= ST_IDLE;
            z          <= '0;
            dwell_cnt  <= '0;
            snapshot   <= '0;
            SerLatch   <= 1'b0;
            FrameStart <= 1'b0;
            LayerSel   <= '0;
        end else begin
            state      <= next_state;
            z          <= z_next;
            dwell_cnt  <= (state == ST_DWELL && !dwell_end) ? dwell_cnt + 16'd1 : 16'd0;
            if (load_layer && z == 3'd0) begin
                snapshot <= Cells;
            end
            SerLatch   <= (next_state == ST_LATCH);
            FrameStart <= (next_state == ST_LOAD) && (z_next == 3'd0);
            LayerSel   <= (next_state == ST_DWELL && !Blank) ? layer_onehot(z_next) : '0;
        end
    end

    col_shifter #(
        .SHIFT_HALF(SHIFT_HALF)
    ) u_col_shifter (
        .clk   (Clk),
        .rst_n (Reset),
        .load  (load_layer),
        .data  (layer_data),
        .start (load_layer),
        .busy  (sh_busy),
        .sclk  (SerClk),
        .sdata (SerData)
    );
endmodule

// File: tb/tb_cube_scan.sv
// Directed bench for cube_scan: table of whole-frame vectors plus hand sequences
// for tearing, enable drop, mid-dwell blank and mid-dwell reset.
module tb_cube_scan;
    localparam int SH        = 2;
    localparam int DW        = 4;
    localparam int SHIFT_LEN = 128 * SH;

    logic         Clk = 1'b0;
    logic         Reset;
    logic [511:0] Cells;
    logic         Enable;
    logic         Blank;
    logic         SerClk, SerData, SerLatch, FrameStart;
    logic [7:0]   LayerSel;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [511:0]     cells;
        logic             blank;
        logic [7:0][63:0] words;
    } vec_t;

    vec_t vecs[4];

    cube_scan #(.SHIFT_HALF(SH), .DWELL_CYCLES(DW)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Cells      (Cells),
        .Enable     (Enable),
        .Blank      (Blank),
        .SerClk     (SerClk),
        .SerData    (SerData),
        .SerLatch   (SerLatch),
        .LayerSel   (LayerSel),
        .FrameStart (FrameStart)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic reset_dut();
        Enable = 1'b0;
        Reset  = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
    endtask

    // Called with the next rising edge entering LOAD; returns after the last DWELL sample.
    task automatic run_layer(input int z, input logic [63:0] exp_word, input logic exp_fs,
                             input logic blank_all, input logic drop_en,
                             input logic blank_mid, input logic rst_dwell);
        logic [63:0] word;
        logic [7:0]  exp_sel;
        logic        prev_clk, prev_dat;
        int rises, run_len, hp_bad, data_bad, side_bad, sel_bad;
        word = '0; rises = 0; run_len = 0; hp_bad = 0; data_bad = 0; side_bad = 0; sel_bad = 0;

        @(negedge Clk);
        check($sformatf("L%0d frame_start", z), 64'(FrameStart), 64'(exp_fs));
        check($sformatf("L%0d load_quiet", z), 64'({SerClk, SerLatch, LayerSel}), 64'd0);
        prev_clk = SerClk;
        prev_dat = SerData;

        for (int c = 0; c < SHIFT_LEN; c++) begin
            @(negedge Clk);
            if (SerClk && !prev_clk) begin
                word = {word[62:0], SerData};
                rises++;
            end
            if (SerClk && SerData !== prev_dat) data_bad++;
            if (SerClk == prev_clk) run_len++;
            else begin
                if (run_len != SH) hp_bad++;
                run_len = 1;
            end
            if (LayerSel !== 8'h00 || SerLatch !== 1'b0 || FrameStart !== 1'b0) side_bad++;
            prev_clk = SerClk;
            prev_dat = SerData;
            if (drop_en && c == 10) Enable = 1'b0;
        end
        if (run_len != SH) hp_bad++;
        check($sformatf("L%0d rises", z), 64'(rises), 64'd64);
        check($sformatf("L%0d word", z), word, exp_word);
        check($sformatf("L%0d half_period", z), 64'(hp_bad), 64'd0);
        check($sformatf("L%0d data_stable", z), 64'(data_bad), 64'd0);
        check($sformatf("L%0d shift_quiet", z), 64'(side_bad), 64'd0);

        @(negedge Clk);
        check($sformatf("L%0d latch", z), 64'({SerLatch, SerClk, LayerSel}), 64'h200);

        for (int c = 0; c < DW; c++) begin
            @(negedge Clk);
            if (rst_dwell && c == 2) begin
                #2 Reset = 1'b0;
                #1 check($sformatf("L%0d reset_outputs", z),
                         64'({SerClk, SerData, SerLatch, FrameStart, LayerSel}), 64'd0);
                return;
            end
            exp_sel = (blank_all || (blank_mid && c >= 2)) ? 8'h00 : (8'h01 << z);
            if (LayerSel !== exp_sel || SerLatch !== 1'b0) sel_bad++;
            if (blank_mid && c == 1) Blank = 1'b1;
        end
        check($sformatf("L%0d dwell_sel", z), 64'(sel_bad), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched + 1);
        $fatal(1);
    end

    initial begin
        vecs[0].cells = '0;
        vecs[0].blank = 1'b0;
        vecs[0].words = '0;

        vecs[1].cells = {448'h0, 64'h8000_0000_0000_0000};
        vecs[1].blank = 1'b0;
        vecs[1].words = {448'h0, 64'h8000_0000_0000_0000};

        vecs[2].cells = {64'hC000_0000_0000_0003, 64'h1234_5678_9ABC_DEF0,
                         64'h0F0F_0F0F_F0F0_F0F0, 64'h8000_0000_0000_0001,
                         64'hA5A5_A5A5_5A5A_5A5A, 64'hFFFF_FFFF_FFFF_FFFF,
                         64'h0000_0000_0000_0001, 64'hDEAD_BEEF_0123_4567};
        vecs[2].blank = 1'b0;
        vecs[2].words[0] = 64'hDEAD_BEEF_0123_4567;
        vecs[2].words[1] = 64'h0000_0000_0000_0001;
        vecs[2].words[2] = 64'hFFFF_FFFF_FFFF_FFFF;
        vecs[2].words[3] = 64'hA5A5_A5A5_5A5A_5A5A;
        vecs[2].words[4] = 64'h8000_0000_0000_0001;
        vecs[2].words[5] = 64'h0F0F_0F0F_F0F0_F0F0;
        vecs[2].words[6] = 64'h1234_5678_9ABC_DEF0;
        vecs[2].words[7] = 64'hC000_0000_0000_0003;

        vecs[3]       = vecs[2];
        vecs[3].blank = 1'b1;

        Reset  = 1'b1;
        Enable = 1'b0;
        Blank  = 1'b0;
        Cells  = '0;
        #1 Reset = 1'b0;
        #2 check("reset_outputs", 64'({SerClk, SerData, SerLatch, FrameStart, LayerSel}), 64'd0);
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        begin
            int quiet_bad = 0;
            repeat (5) begin
                @(negedge Clk);
                if ({SerClk, SerLatch, FrameStart, LayerSel} !== 11'd0) quiet_bad++;
            end
            check("idle_disabled", 64'(quiet_bad), 64'd0);
        end

        for (int v = 0; v < 4; v++) begin
            reset_dut();
            Cells  = vecs[v].cells;
            Blank  = vecs[v].blank;
            Enable = 1'b1;
            for (int z = 0; z < 8; z++)
                run_layer(z, vecs[v].words[z], z == 0, vecs[v].blank, 1'b0, 1'b0, 1'b0);
            run_layer(0, vecs[v].words[0], 1'b1, vecs[v].blank, 1'b0, 1'b0, 1'b0);
        end
        Blank = 1'b0;

        // Cells change mid-frame: layers 3..7 keep the snapshot, next frame picks it up.
        reset_dut();
        Cells  = '0;
        Enable = 1'b1;
        for (int z = 0; z < 3; z++) run_layer(z, 64'h0, z == 0, 1'b0, 1'b0, 1'b0, 1'b0);
        Cells = {512{1'b1}};
        for (int z = 3; z < 8; z++) run_layer(z, 64'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_layer(0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_layer(1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Enable dropped during layer 5 shift: layer completes, then idle, resume at layer 6.
        for (int z = 2; z < 5; z++) run_layer(z, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_layer(5, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        begin
            int quiet_bad = 0;
            repeat (6) begin
                @(negedge Clk);
                if ({SerClk, SerLatch, FrameStart, LayerSel} !== 11'd0) quiet_bad++;
            end
            check("idle_after_drop", 64'(quiet_bad), 64'd0);
        end
        Enable = 1'b1;
        run_layer(6, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        Blank = 1'b0;
        run_layer(7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_layer(0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        // Reset pulsed mid-dwell of layer 7, then restart from layer 0 with a new pattern.
        for (int z = 1; z < 7; z++) run_layer(z, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_layer(7, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge Clk);
        Cells = vecs[2].cells;
        Reset = 1'b1;
        run_layer(0, 64'hDEAD_BEEF_0123_4567, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        run_layer(1, 64'h0000_0000_0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
